// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
//   - ALU opcode constants and the highest legal opcode.
//   - Arbiter FSM state encoding (IDLE / EXEC / RESP).
//   - op_is_legal(): opcode legality test used when ALU_SHARE_OPCHECK_EN is defined.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_MUL    = 4'd2;
  localparam logic [3:0] ALU_AND    = 4'd3;
  localparam logic [3:0] ALU_OR     = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_OP_MAX = 4'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by several requesters.
// Ports:
//   op     [OP_W-1:0]   opcode (ADD/SUB/MUL/AND/OR/SLL/SRL)
//   a, b   [DATA_W-1:0] operands
//   result [DATA_W-1:0] result, wrapped mod 2^DATA_W; undefined opcodes give 0.
// Shift amounts use only the low $clog2(DATA_W) bits of b.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt_s;

  assign shamt_s = b[SH_W-1:0];

  // Opcode decode and datapath.
  always_comb begin
    result = {DATA_W{1'b0}};
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_MUL: result = a * b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << shamt_s;
      ALU_SRL: result = a >> shamt_s;
      default: result = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker.
// Ports:
//   req        [NUM_REQ-1:0] request vector
//   last_grant [ID_W-1:0]    previous winner; the search starts just above it
//   grant      [NUM_REQ-1:0] one-hot winner (zero when no request)
//   grant_idx  [ID_W-1:0]    index of the winner
//   valid                    at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               valid
);

  // Scan last_grant+1 .. last_grant+NUM_REQ with wrap; the first set request wins.
  // One extra bit holds the unwrapped sum (at most 2*NUM_REQ-1).
  always_comb begin : pick
    logic [ID_W:0] cand;
    logic          found;
    cand      = {(ID_W+1){1'b0}};
    found     = 1'b0;
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(i + 32'sd1);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!found && req[cand[ID_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[ID_W-1:0]]    = 1'b1;
        grant_idx                = cand[ID_W-1:0];
      end else begin
        found = found;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration.
// A request is accepted in IDLE (req_ready pulses combinationally for the winner),
// executed in EXEC, and the tagged, registered result is offered in RESP until
// rsp_ready. Accept at cycle N -> rsp_valid in cycle N+2; one request in flight.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake (ready one-hot or zero)
//   req_a, req_b, req_op       packed per-requester payload, requester i at [i*W +: W]
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_id, rsp_err  result, owning requester, illegal-opcode flag
//   busy                       high whenever the FSM is not IDLE
// Build option: define ALU_SHARE_OPCHECK_EN to flag opcodes above ALU_OP_MAX with
// rsp_err=1 and rsp_data=0; otherwise rsp_err is constant 0.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = 32,
  parameter  int OP_W    = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err,
  output logic                      busy
);

  logic [1:0]          state_r;
  logic [ID_W-1:0]     last_grant_r;
  logic [ID_W-1:0]     id_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [OP_W-1:0]     op_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic                rsp_err_r;

  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic                grant_valid_s;
  logic [DATA_W-1:0]   win_a_s;
  logic [DATA_W-1:0]   win_b_s;
  logic [OP_W-1:0]     win_op_s;
  logic [DATA_W-1:0]   alu_result_s;
  logic [DATA_W-1:0]   exec_data_s;
  logic                exec_err_s;
  logic                accept_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s),
    .valid      (grant_valid_s)
  );

  alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_result_s)
  );

  assign win_a_s  = req_a[grant_idx_s*DATA_W +: DATA_W];
  assign win_b_s  = req_b[grant_idx_s*DATA_W +: DATA_W];
  assign win_op_s = req_op[grant_idx_s*OP_W +: OP_W];

  // Handshake: only in IDLE and never while reset is held, so req_ready reads 0 in reset.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    accept_s  = 1'b0;
    if (rst_n && (state_r == ST_IDLE)) begin
      req_ready = grant_s;
      accept_s  = grant_valid_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
      accept_s  = 1'b0;
    end
  end

`ifdef ALU_SHARE_OPCHECK_EN
  logic illegal_r;

  // Legality of the accepted opcode, evaluated once at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      illegal_r <= !op_is_legal(win_op_s);
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign exec_err_s  = illegal_r;
  assign exec_data_s = illegal_r ? {DATA_W{1'b0}} : alu_result_s;
`else
  assign exec_err_s  = 1'b0;
  assign exec_data_s = alu_result_s;
`endif

  // Main FSM: accept/latch in IDLE, register ALU result in EXEC, hold response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= ID_W'(NUM_REQ - 1);
      id_r         <= {ID_W{1'b0}};
      a_r          <= {DATA_W{1'b0}};
      b_r          <= {DATA_W{1'b0}};
      op_r         <= {OP_W{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= {DATA_W{1'b0}};
      rsp_id_r     <= {ID_W{1'b0}};
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r          <= win_a_s;
            b_r          <= win_b_s;
            op_r         <= win_op_s;
            id_r         <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            state_r      <= ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_data_r  <= exec_data_s;
          rsp_err_r   <= exec_err_s;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (3 requesters, 32-bit data).
// Directed scenarios followed by a randomized run against a cycle-level reference
// model (round-robin pointer, one-outstanding-request timing, plain-arithmetic ALU).
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int IW = $clog2(N);
`ifdef ALU_SHARE_OPCHECK_EN
  localparam logic EXP_ILLEGAL_ERR = 1'b1;
`else
  localparam logic EXP_ILLEGAL_ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*OW-1:0] req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            rsp_err;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a << (b % 32);
      4'd6: return a >> (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = 1'b1;
    req_op[i*OW +: OW]  = op;
    req_a[i*DW +: DW]   = a;
    req_b[i*DW +: DW]   = b;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 3'b000) $display("FAIL reset_req_ready: got %b want 000", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 32'd0) $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); else n_pass++;
    n_checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    set_req(0, ALU_ADD, 32'd10, 32'd5); rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b001) $display("FAIL add_ready: got %b want 001", req_ready); else n_pass++;
    @(posedge clk); #1 clr_req(0);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL add_exec_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL add_exec_busy: got %b want 1", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 32'd15) $display("FAIL add_rsp_data: got %0d want 15", rsp_data); else n_pass++;
    n_checks++; if (rsp_id !== 2'd0) $display("FAIL add_rsp_id: got %0d want 0", rsp_id); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL add_consumed_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL add_idle_busy: got %b want 0", busy); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_two_req();
    int g[$]; int gc[$]; int ri[$]; int rc[$]; logic [31:0] rd[$];
    logic [N-1:0] rdy; bit busy_ok; bit exec_next;
    busy_ok = 1'b1; exec_next = 1'b0;
    do_reset();
    set_req(0, ALU_SUB, 32'd20, 32'd7); set_req(1, ALU_MUL, 32'd6, 32'd7); rsp_ready = 1'b1;
    for (int c = 0; c < 30 && rd.size() < 2; c++) begin
      @(negedge clk);
      rdy = req_ready;
      if (exec_next && busy !== 1'b1) busy_ok = 1'b0;
      if (rsp_valid === 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
      exec_next = (rdy != '0);
      if (rdy != '0) begin g.push_back(onehot_idx(rdy)); gc.push_back(c); end
      if (rsp_valid === 1'b1 && rsp_ready) begin rd.push_back(rsp_data); ri.push_back(int'(rsp_id)); rc.push_back(c); end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (rdy[i]) clr_req(i);
    end
    n_checks++; if (rd.size() !== 2) $display("FAIL two_rsp_count: got %0d want 2", rd.size()); else n_pass++;
    if (rd.size() == 2 && g.size() >= 2) begin
      n_checks++; if (ri[0] !== 0) $display("FAIL two_first_id: got %0d want 0", ri[0]); else n_pass++;
      n_checks++; if (rd[0] !== 32'd13) $display("FAIL two_first_data: got %0d want 13", rd[0]); else n_pass++;
      n_checks++; if (ri[1] !== 1) $display("FAIL two_second_id: got %0d want 1", ri[1]); else n_pass++;
      n_checks++; if (rd[1] !== 32'd42) $display("FAIL two_second_data: got %0d want 42", rd[1]); else n_pass++;
      n_checks++; if (rc[0] - gc[0] !== 2) $display("FAIL two_latency: got %0d want 2", rc[0] - gc[0]); else n_pass++;
      n_checks++; if (gc[1] - gc[0] !== 3) $display("FAIL two_issue_interval: got %0d want 3", gc[1] - gc[0]); else n_pass++;
    end
    n_checks++; if (busy_ok !== 1'b1) $display("FAIL two_busy: got %b want 1", busy_ok); else n_pass++;
  endtask

  task automatic test_continuous();
    int g[$]; int ri[$]; logic [31:0] rd[$]; logic [N-1:0] rdy;
    do_reset();
    set_req(0, ALU_SLL, 32'd1, 32'd4); set_req(1, ALU_SRL, 32'd16, 32'd2); rsp_ready = 1'b1;
    for (int c = 0; c < 40 && rd.size() < 3; c++) begin
      @(negedge clk);
      rdy = req_ready;
      if (rdy != '0) g.push_back(onehot_idx(rdy));
      if (rsp_valid === 1'b1) begin rd.push_back(rsp_data); ri.push_back(int'(rsp_id)); end
      @(posedge clk); #1;
      if (rdy[1]) clr_req(1);
    end
    clr_req(0);
    n_checks++; if (rd.size() !== 3) $display("FAIL cont_rsp_count: got %0d want 3", rd.size()); else n_pass++;
    if (rd.size() == 3 && g.size() >= 3) begin
      n_checks++; if (g[0] !== 0 || g[1] !== 1 || g[2] !== 0) $display("FAIL cont_grants: got %0d,%0d,%0d want 0,1,0", g[0], g[1], g[2]); else n_pass++;
      n_checks++; if (rd[0] !== 32'd16 || rd[1] !== 32'd4 || rd[2] !== 32'd16) $display("FAIL cont_data: got %0d,%0d,%0d want 16,4,16", rd[0], rd[1], rd[2]); else n_pass++;
      n_checks++; if (ri[0] !== 0 || ri[1] !== 1 || ri[2] !== 0) $display("FAIL cont_ids: got %0d,%0d,%0d want 0,1,0", ri[0], ri[1], ri[2]); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit stall_ok;
    stall_ok = 1'b1;
    set_req(0, ALU_AND, 32'd12, 32'd10); rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b001) $display("FAIL bp_accept: got %b want 001", req_ready); else n_pass++;
    @(posedge clk); #1 clr_req(0); set_req(1, ALU_ADD, 32'd1, 32'd2);
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b000) $display("FAIL bp_exec_ready: got %b want 000", req_ready); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd8 || req_ready !== 3'b000) stall_ok = 1'b0;
    end
    n_checks++; if (stall_ok !== 1'b1) $display("FAIL bp_stall_hold: got %b want 1", stall_ok); else n_pass++;
    n_checks++; if (rsp_data !== 32'd8) $display("FAIL bp_data: got %0d want 8", rsp_data); else n_pass++;
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b000) $display("FAIL bp_consume_ready: got %b want 000", req_ready); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b010) $display("FAIL bp_accept_after: got %b want 010", req_ready); else n_pass++;
    @(posedge clk); #1 clr_req(1);
    @(negedge clk); @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_id !== 2'd1) $display("FAIL bp_second_rsp: got v=%b d=%0d id=%0d want v=1 d=3 id=1", rsp_valid, rsp_data, rsp_id); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit nores; bit done; logic [N-1:0] rdy; logic [31:0] rd[$];
    nores = 1'b1; done = 1'b0;
    set_req(0, ALU_OR, 32'd12, 32'd10); rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b001) $display("FAIL rst_or_accept: got %b want 001", req_ready); else n_pass++;
    @(posedge clk); #1 clr_req(0);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_exec_busy: got %b want 1", busy); else n_pass++;
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'd0) $display("FAIL rst_outputs: got v=%b busy=%b d=%0d want 0,0,0", rsp_valid, busy, rsp_data); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (rsp_valid !== 1'b0) nores = 1'b0; end
    n_checks++; if (nores !== 1'b1) $display("FAIL rst_no_response: got %b want 1", nores); else n_pass++;
    @(posedge clk); #1 set_req(0, ALU_ADD, 32'd7, 32'd8); set_req(1, ALU_ADD, 32'd1, 32'd1);
    @(negedge clk);
    rdy = req_ready;
    n_checks++; if (rdy !== 3'b001) $display("FAIL rst_first_grant: got %b want 001", rdy); else n_pass++;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (rdy[i]) clr_req(i);
      @(negedge clk);
      rdy = req_ready;
      if (rsp_valid === 1'b1) rd.push_back(rsp_data);
      done = (req_valid == '0) && (rsp_valid === 1'b0) && (busy === 1'b0);
    end
    n_checks++; if (done !== 1'b1) $display("FAIL rst_drain_timeout: got %b want 1", done); else n_pass++;
    n_checks++; if (rd.size() !== 2) $display("FAIL rst_drain_count: got %0d want 2", rd.size()); else n_pass++;
    if (rd.size() == 2) begin
      n_checks++; if (rd[0] !== 32'd15 || rd[1] !== 32'd2) $display("FAIL rst_drain_data: got %0d,%0d want 15,2", rd[0], rd[1]); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_op();
    set_req(2, 4'b1111, 32'd5, 32'd3); rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 3'b100) $display("FAIL ill_accept: got %b want 100", req_ready); else n_pass++;
    @(posedge clk); #1 clr_req(2);
    @(negedge clk); @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) $display("FAIL ill_rsp: got v=%b id=%0d want 1,2", rsp_valid, rsp_id); else n_pass++;
    n_checks++; if (rsp_err !== EXP_ILLEGAL_ERR) $display("FAIL ill_err: got %b want %b", rsp_err, EXP_ILLEGAL_ERR); else n_pass++;
`ifdef ALU_SHARE_OPCHECK_EN
    n_checks++; if (rsp_data !== 32'd0) $display("FAIL ill_data: got %0d want 0", rsp_data); else n_pass++;
`endif
    @(posedge clk); #1 set_req(2, ALU_ADD, 32'd5, 32'd3);
    @(negedge clk);
    @(posedge clk); #1 clr_req(2);
    @(negedge clk); @(negedge clk);
    n_checks++; if (rsp_err !== 1'b0 || rsp_data !== 32'd8) $display("FAIL ill_legal_after: got err=%b d=%0d want 0,8", rsp_err, rsp_data); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit free; bit pending; int resp_cycle; int model_last; int w;
    logic [31:0] exp_data; int exp_id; bit drop[N]; logic [N-1:0] exp_rdy; bit exp_valid;
    do_reset();
    free = 1'b1; pending = 1'b0; resp_cycle = 0; model_last = N - 1; exp_data = 32'd0; exp_id = 0;
    for (int i = 0; i < N; i++) drop[i] = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (drop[i]) begin clr_req(i); drop[i] = 1'b0; end
        if (!req_valid[i] && $urandom_range(0, 99) < 40)
          set_req(i, 4'($urandom_range(0, 6)), $urandom, $urandom);
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      exp_rdy = '0; w = -1;
      if (free && req_valid != '0) begin
        for (int k = 1; k <= N && w < 0; k++) if (req_valid[(model_last + k) % N]) w = (model_last + k) % N;
        exp_rdy[w] = 1'b1;
      end
      exp_valid = pending && (cyc >= resp_cycle);
      n_checks++; if (req_ready !== exp_rdy) $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, req_ready, exp_rdy); else n_pass++;
      n_checks++; if (rsp_valid !== exp_valid) $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, rsp_valid, exp_valid); else n_pass++;
      n_checks++; if (busy !== !free) $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, busy, !free); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (rsp_data !== exp_data) $display("FAIL rand_data cyc %0d: got %h want %h", cyc, rsp_data, exp_data); else n_pass++;
        n_checks++; if (int'(rsp_id) !== exp_id || rsp_err !== 1'b0) $display("FAIL rand_id_err cyc %0d: got id=%0d err=%b want id=%0d err=0", cyc, rsp_id, rsp_err, exp_id); else n_pass++;
        if (rsp_ready) begin pending = 1'b0; free = 1'b1; end
      end
      if (w >= 0) begin
        free = 1'b0; pending = 1'b1; resp_cycle = cyc + 2; model_last = w; exp_id = w; drop[w] = 1'b1;
        exp_data = ref_alu(req_op[w*OW +: OW], req_a[w*DW +: DW], req_b[w*DW +: DW]);
      end
      @(posedge clk); #1;
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_two_req();
    test_continuous();
    test_backpressure();
    test_reset_mid();
    test_illegal_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
